exp_table_buffer: RTL and testbench
===================================

# exp_table_buffer

Downstream consumer of the exp(x·sigma) table generator. It captures the generator's (address, data) stream into an internal single-write/single-read RAM, maps signed x addresses to zero-based indices, and accumulates the sum of all captured values for later normalisation. Once a fill completes, it serves random-access reads to the risk-evaluation stage.

## Interface
- `X_MIN`, default -307: signed x of the first table entry; maps to index 0.
- `DEPTH`, default 588: number of table entries (X_MIN..X_MIN+DEPTH-1); ≤ 1024.
- `AW`, default 10: width of the incoming signed address and of the read index.
- `DW`, default 18: data width (unsigned, 3 int / 15 fract).
- `SW`, default 28: sum width; DW+AW, so it cannot overflow for DEPTH ≤ 1024.
- `CLK` input 1: the single clock; all logic on posedge.
- `RST` input 1: asynchronous, active-high reset.
- `iStart` input 1: begin a new fill; clears the sum and counters.
- `iValid` input 1: the `iAddr`/`iData` pair is valid this cycle.
- `iAddr` input AW: signed two's-complement x of the sample.
- `iData` input DW: exp value for that x.
- `iDone` input 1: end-of-table pulse from the generator.
- `iRdAddr` input AW: zero-based read index.
- `oRdData` output DW: RAM word at the `iRdAddr` sampled on the previous edge.
- `oRdValid` output 1: `oRdData` is meaningful (the read was issued in READY).
- `oSum` output SW: running sum of accepted samples.
- `oCount` output AW+1: number of accepted writes.
- `oReady` output 1: high in READY; the table is complete.
- `oErr` output 1: sticky; an out-of-range address was seen during this fill.

## Operation
- **States:** IDLE, FILL, READY. Reset enters IDLE.
- **IDLE:**
  - `iStart` → FILL; clear `oSum`, `oCount`, `oErr`.
  - `iValid` is ignored.
- **FILL:**
  - Index = `iAddr` − `X_MIN`, computed in AW+1 bits, signed.
  - An `iValid` sample is accepted when 0 ≤ index < DEPTH. On acceptance:
    - `RAM[index]` ← `iData`;
    - `oSum` += zero-extended `iData`;
    - `oCount` += 1.
  - An out-of-range `iValid` sample is not written or summed; it sets `oErr`.
  - A duplicate index overwrites the RAM word, and both values are summed (no dedup).
  - `iDone` → READY. An `iValid` in the same cycle as `iDone` is still accepted.
  - `iStart` while in FILL restarts the fill: sum, count and err are cleared, and any simultaneous `iValid` is dropped.
- **READY:**
  - `oSum`, `oCount` and `oErr` are frozen.
  - `iStart` → FILL, with a clear as above.
  - `iValid` is ignored.
- **Reads:**
  - A read port is available in every state.
  - `oRdValid` ← (state == READY) on the read edge.
  - If `iRdAddr` ≥ DEPTH, `oRdData` = 0.
- **RAM:** contents are not cleared by reset or by `iStart`.

## Timing
- **Reset values:**
  - `oRdData` = 0, `oRdValid` = 0, `oSum` = 0, `oCount` = 0, `oReady` = 0, `oErr` = 0.
  - State = IDLE.
- **Write latency:** a sample accepted at edge N is readable by a read issued at edge N+1 (data out at N+2). Same-cycle write and read to the same index returns the old data.
- **Sum/count latency:** they reflect the sample one edge after acceptance.
- **`oReady`:** rises on the edge that samples `iDone`; it falls on the edge that samples `iStart`.
- **Read latency:** `oRdData` and `oRdValid` are registered, 1 cycle.
- **Throughput:** one sample per cycle, with no backpressure.
- **Reset mid-FILL:** the block returns to IDLE immediately (asynchronously). A partial sum is discarded, and RAM holds whatever was written.

## Configuration
- **`EXP_TABLE_MAX_EN` defined:** adds outputs `oMax` (DW) and `oMaxIdx` (AW).
  - Both reset to 0 and are cleared on `iStart`.
  - Updated on each accepted sample with `iData` > `oMax`. Ties keep the earlier index.
  - Frozen in READY.
- **Undefined:** no ports and no max logic.

## Test plan
- **Full fill:** reset, `iStart`, then x = -307..280 with `iData` = 1024 each cycle, then `iDone` → `oReady` = 1, `oCount` = 588, `oSum` = 602112, `oErr` = 0.
- **Readback:** fill with `iData` = index, then in READY read indices 0, 287, 587 → `oRdData` 0, 287, 587 one cycle later, `oRdValid` = 1. Read 600 → 0.
- **Out-of-range:** in FILL send x = -308 and x = 281 with data 5 → `oErr` = 1, `oCount` unchanged, `oSum` unchanged.
- **Restart and simultaneous events:** `iValid` together with `iDone` (x = 280, data 7) → accepted, `oCount` increments, READY. Then `iStart` → `oReady` drops, `oSum` = 0.
- **Reset mid-fill:** after 100 samples, assert `RST` for 1 cycle → all outputs 0, IDLE. A subsequent `iValid` without `iStart` is ignored.
- **`EXP_TABLE_MAX_EN`:** samples 3, 9, 9, 4 at indices 0..3 → `oMax` = 9, `oMaxIdx` = 1.

Source files
------------

// File: rtl/exp_table_buffer.sv
// Capture buffer for the exp(x*sigma) table: maps signed x to a RAM index, sums accepted samples,
// then serves registered random reads. Define EXP_TABLE_MAX_EN to add running-max tracking (oMax/oMaxIdx).
module exp_table_buffer #(
  parameter int X_MIN = -307,
  parameter int DEPTH = 588,
  parameter int AW    = 10,
  parameter int DW    = 18,
  parameter int SW    = 28
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          iStart,
  input  logic          iValid,
  input  logic [AW-1:0] iAddr,
  input  logic [DW-1:0] iData,
  input  logic          iDone,
  input  logic [AW-1:0] iRdAddr,
  output logic [DW-1:0] oRdData,
  output logic          oRdValid,
  output logic [SW-1:0] oSum,
  output logic [AW:0]   oCount,
  output logic          oReady,
  output logic          oErr
`ifdef EXP_TABLE_MAX_EN
  ,
  output logic [DW-1:0] oMax,
  output logic [AW-1:0] oMaxIdx
`endif
);

  localparam logic signed [AW:0] L_XMIN  = (AW+1)'(X_MIN);
  localparam logic        [AW:0] L_DEPTH = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic               w_clear;
  logic               w_accept;
  logic               w_reject;
  logic signed [AW:0] w_index;
  logic               w_inRange;
  logic [AW-1:0]      w_wrIdx;
  logic               w_rdInRange;

  logic [DW-1:0] r_ram [0:DEPTH-1];
  logic [SW-1:0] r_sum;
  logic [AW:0]   r_count;
  logic          r_err;
  logic [DW-1:0] r_rdData;
  logic          r_rdValid;

  // Index is formed one bit wider than the address so negative offsets stay detectable.
  assign w_index     = $signed({iAddr[AW-1], iAddr}) - L_XMIN;
  assign w_inRange   = !w_index[AW] && ({1'b0, w_index[AW-1:0]} < L_DEPTH);
  assign w_wrIdx     = w_index[AW-1:0];
  assign w_rdInRange = {1'b0, iRdAddr} < L_DEPTH;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A restart in FILL wins over any sample or done pulse arriving in the same cycle.
  always_comb begin
    w_nextState = r_state;
    w_clear     = 1'b0;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (iStart) begin
          w_nextState = S_FILL;
          w_clear     = 1'b1;
        end
      end
      S_FILL: begin
        if (iStart) begin
          w_clear = 1'b1;
        end else begin
          if (iValid) begin
            w_accept = w_inRange;
            w_reject = !w_inRange;
          end
          if (iDone) begin
            w_nextState = S_READY;
          end
        end
      end
      S_READY: begin
        if (iStart) begin
          w_nextState = S_FILL;
          w_clear     = 1'b1;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Table storage has no reset so it can map onto block RAM.
  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_ram[w_wrIdx] <= iData;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sum   <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (w_clear) begin
      r_sum   <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sum   <= r_sum + SW'(iData);
        r_count <= r_count + 1'b1;
      end
      if (w_reject) begin
        r_err <= 1'b1;
      end
    end
  end

  // Read-before-write: a same-cycle write to the read index is seen one read later.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rdData  <= '0;
      r_rdValid <= 1'b0;
    end else begin
      r_rdValid <= (r_state == S_READY);
      if (w_rdInRange) begin
        r_rdData <= r_ram[iRdAddr];
      end else begin
        r_rdData <= '0;
      end
    end
  end

`ifdef EXP_TABLE_MAX_EN
  logic [DW-1:0] r_max;
  logic [AW-1:0] r_maxIdx;

  // Strict greater-than keeps the earliest index on ties.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_max    <= '0;
      r_maxIdx <= '0;
    end else if (w_clear) begin
      r_max    <= '0;
      r_maxIdx <= '0;
    end else if (w_accept && (iData > r_max)) begin
      r_max    <= iData;
      r_maxIdx <= w_wrIdx;
    end
  end

  assign oMax    = r_max;
  assign oMaxIdx = r_maxIdx;
`endif

  assign oRdData  = r_rdData;
  assign oRdValid = r_rdValid;
  assign oSum     = r_sum;
  assign oCount   = r_count;
  assign oReady   = (r_state == S_READY);
  assign oErr     = r_err;

endmodule

// File: tb/tb_exp_table_buffer.sv
// Directed bench for exp_table_buffer: a behavioural table model predicts sum/count/err/ready,
// and a queue of expected read results is compared one cycle after each read is issued.
module tb_exp_table_buffer;

  localparam int XMIN  = -307;
  localparam int DEPTH = 588;
  localparam int AW    = 10;
  localparam int DW    = 18;
  localparam int SW    = 28;

  logic          CLK = 1'b0;
  logic          RST;
  logic          iStart;
  logic          iValid;
  logic [AW-1:0] iAddr;
  logic [DW-1:0] iData;
  logic          iDone;
  logic [AW-1:0] iRdAddr;
  logic [DW-1:0] oRdData;
  logic          oRdValid;
  logic [SW-1:0] oSum;
  logic [AW:0]   oCount;
  logic          oReady;
  logic          oErr;
`ifdef EXP_TABLE_MAX_EN
  logic [DW-1:0] oMax;
  logic [AW-1:0] oMaxIdx;
`endif

  exp_table_buffer #(
    .X_MIN(XMIN), .DEPTH(DEPTH), .AW(AW), .DW(DW), .SW(SW)
  ) dut (
    .CLK(CLK), .RST(RST), .iStart(iStart), .iValid(iValid), .iAddr(iAddr),
    .iData(iData), .iDone(iDone), .iRdAddr(iRdAddr), .oRdData(oRdData),
    .oRdValid(oRdValid), .oSum(oSum), .oCount(oCount), .oReady(oReady), .oErr(oErr)
`ifdef EXP_TABLE_MAX_EN
    , .oMax(oMax), .oMaxIdx(oMaxIdx)
`endif
  );

  always #5 CLK = ~CLK;

  typedef enum int {M_IDLE, M_FILL, M_READY} mstate_t;
  typedef struct {
    bit            known;
    logic [DW-1:0] data;
    logic          valid;
  } rdExp_t;

  int            checks   = 0;
  int            failures = 0;
  mstate_t       mState;
  int            mSum;
  int            mCount;
  logic          mErr;
  logic [DW-1:0] modelRam   [0:DEPTH-1];
  bit            modelKnown [0:DEPTH-1];
  rdExp_t        rdQueue[$];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkAll();
    rdExp_t e;
    checkOutput("rdQueueNonEmpty", 32'(rdQueue.size() != 0), 32'd1);
    if (rdQueue.size() != 0) begin
      e = rdQueue.pop_front();
      checkOutput("rdValid", 32'(oRdValid), 32'(e.valid));
      if (e.known) checkOutput("rdData", 32'(oRdData), 32'(e.data));
    end
    checkOutput("sum", 32'(oSum), 32'(mSum));
    checkOutput("count", 32'(oCount), 32'(mCount));
    checkOutput("err", 32'(oErr), 32'(mErr));
    checkOutput("ready", 32'(oReady), 32'(mState == M_READY));
  endtask

  task automatic modelClear();
    mSum   = 0;
    mCount = 0;
    mErr   = 1'b0;
  endtask

  task automatic applyStimulus(input logic start, input logic valid, input int x,
                               input int data, input logic done, input int rdAddr);
    rdExp_t e;
    int idx;
    iStart  = start;
    iValid  = valid;
    iAddr   = AW'(x);
    iData   = DW'(data);
    iDone   = done;
    iRdAddr = AW'(rdAddr);
    e.valid = (mState == M_READY);
    if (rdAddr >= DEPTH) begin
      e.known = 1'b1;
      e.data  = '0;
    end else begin
      e.known = modelKnown[rdAddr];
      e.data  = modelRam[rdAddr];
    end
    rdQueue.push_back(e);
    case (mState)
      M_IDLE: if (start) begin mState = M_FILL; modelClear(); end
      M_FILL: begin
        if (start) begin
          modelClear();
        end else begin
          if (valid) begin
            idx = x - XMIN;
            if (idx >= 0 && idx < DEPTH) begin
              modelRam[idx]   = DW'(data);
              modelKnown[idx] = 1'b1;
              mSum   += data;
              mCount += 1;
            end else begin
              mErr = 1'b1;
            end
          end
          if (done) mState = M_READY;
        end
      end
      M_READY: if (start) begin mState = M_FILL; modelClear(); end
      default: mState = M_IDLE;
    endcase
    @(posedge CLK);
    #1;
    checkAll();
  endtask

  task automatic doReset();
    RST    = 1'b1;
    iStart = 1'b0;
    iValid = 1'b0;
    iDone  = 1'b0;
    #1;
    checkOutput("rstRdData", 32'(oRdData), 32'd0);
    checkOutput("rstRdValid", 32'(oRdValid), 32'd0);
    checkOutput("rstSum", 32'(oSum), 32'd0);
    checkOutput("rstCount", 32'(oCount), 32'd0);
    checkOutput("rstReady", 32'(oReady), 32'd0);
    checkOutput("rstErr", 32'(oErr), 32'd0);
    @(posedge CLK);
    #1;
    RST    = 1'b0;
    mState = M_IDLE;
    modelClear();
    rdQueue.delete();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    iAddr   = '0;
    iData   = '0;
    iRdAddr = '0;
    mState  = M_IDLE;
    modelClear();
    for (int i = 0; i < DEPTH; i++) modelKnown[i] = 1'b0;
    doReset();

    $display("[TB] full fill with constant data");
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int x = XMIN; x < XMIN + DEPTH; x++) applyStimulus(0, 1, x, 1024, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("fullCount", 32'(oCount), 32'd588);
    checkOutput("fullSum", 32'(oSum), 32'd602112);
    checkOutput("fullReady", 32'(oReady), 32'd1);
    checkOutput("fullErr", 32'(oErr), 32'd0);

    $display("[TB] readback fill with data equal to index");
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("readyDrops", 32'(oReady), 32'd0);
    for (int x = XMIN; x < XMIN + DEPTH; x++) applyStimulus(0, 1, x, x - XMIN, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("rd0", 32'(oRdData), 32'd0);
    checkOutput("rd0Valid", 32'(oRdValid), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 287);
    checkOutput("rd287", 32'(oRdData), 32'd287);
    applyStimulus(0, 0, 0, 0, 0, 587);
    checkOutput("rd587", 32'(oRdData), 32'd587);
    applyStimulus(0, 0, 0, 0, 0, 600);
    checkOutput("rd600", 32'(oRdData), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 1023);
    applyStimulus(0, 0, 0, 0, 0, 300);

    $display("[TB] out-of-range samples and same-cycle read");
    applyStimulus(1, 0, 0, 0, 0, 5);
    applyStimulus(0, 1, -308, 5, 0, 5);
    applyStimulus(0, 1, 281, 5, 0, 5);
    checkOutput("oorErr", 32'(oErr), 32'd1);
    checkOutput("oorCount", 32'(oCount), 32'd0);
    checkOutput("oorSum", 32'(oSum), 32'd0);
    applyStimulus(0, 1, -302, 999, 0, 5);
    checkOutput("sameCycleOld", 32'(oRdData), 32'd5);
    checkOutput("fillRdValid", 32'(oRdValid), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 5);
    checkOutput("nextCycleNew", 32'(oRdData), 32'd999);

    $display("[TB] valid with done, then restart");
    applyStimulus(0, 1, 280, 7, 1, 587);
    checkOutput("doneCount", 32'(oCount), 32'd2);
    checkOutput("doneSum", 32'(oSum), 32'd1006);
    checkOutput("doneReady", 32'(oReady), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 587);
    checkOutput("doneRd587", 32'(oRdData), 32'd7);
    applyStimulus(1, 1, -300, 11, 0, 0);
    checkOutput("restartReady", 32'(oReady), 32'd0);
    checkOutput("restartSum", 32'(oSum), 32'd0);
    checkOutput("restartErr", 32'(oErr), 32'd0);
    applyStimulus(1, 1, -300, 11, 0, 0);
    checkOutput("restartInFillDrop", 32'(oCount), 32'd0);

    $display("[TB] reset in the middle of a fill");
    for (int x = XMIN; x < XMIN + 100; x++) applyStimulus(0, 1, x, 3, 0, 0);
    checkOutput("midCount", 32'(oCount), 32'd100);
    checkOutput("midSum", 32'(oSum), 32'd300);
    doReset();
    applyStimulus(0, 1, -307, 50, 0, 0);
    checkOutput("idleIgnoreCount", 32'(oCount), 32'd0);
    checkOutput("idleIgnoreSum", 32'(oSum), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("ramKept", 32'(oRdData), 32'd3);

`ifdef EXP_TABLE_MAX_EN
    $display("[TB] running maximum");
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, -307, 3, 0, 0);
    applyStimulus(0, 1, -306, 9, 0, 0);
    applyStimulus(0, 1, -305, 9, 0, 0);
    applyStimulus(0, 1, -304, 4, 1, 0);
    checkOutput("maxValue", 32'(oMax), 32'd9);
    checkOutput("maxIdx", 32'(oMaxIdx), 32'd1);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("maxCleared", 32'(oMax), 32'd0);
`endif

    iStart = 1'b0;
    iValid = 1'b0;
    iDone  = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
